// File: rtl/coh_pkg.sv
// Shared encodings for the coherence line controller: line states, bus ops, FSM states.
// Also holds the snoop next-state rule used by the controller.
package coh_pkg;

   localparam logic [1:0] LINE_I = 2'b00;
   localparam logic [1:0] LINE_M = 2'b01;
   localparam logic [1:0] LINE_S = 2'b10;
   localparam logic [1:0] LINE_E = 2'b11;

   localparam logic [1:0] OP_INVALIDATE = 2'b00;
   localparam logic [1:0] OP_WRITE_MISS = 2'b01;
   localparam logic [1:0] OP_READ_MISS  = 2'b10;

   typedef enum logic [1:0] {
      FSM_IDLE = 2'b00,
      FSM_ARB  = 2'b01,
      FSM_DONE = 2'b10
   } fsm_state_t;

   // A remote read demotes an owned line to S; remote writes and invalidates kill it.
   function automatic logic [1:0] snoop_next(input logic [1:0] line, input logic [1:0] op);
      logic [1:0] nxt;
      nxt = line;
      case (op)
         OP_READ_MISS:                 if (line == LINE_M || line == LINE_E) nxt = LINE_S;
         OP_WRITE_MISS, OP_INVALIDATE: nxt = LINE_I;
         default:                      nxt = line;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/coh_state_array.sv
// Per-line coherence state register file with separate cpu and snoop read/write ports.
// The cpu/grant write overrides a snoop write to the same line in the same cycle.
module coh_state_array
   import coh_pkg::*;
#(
   parameter int NUM_LINES = 16,
   parameter int IDX_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] cpu_rd_idx,
   output logic [1:0]       cpu_rd_state,
   input  logic [IDX_W-1:0] snp_rd_idx,
   output logic [1:0]       snp_rd_state,
   input  logic             cpu_wr_en,
   input  logic [IDX_W-1:0] cpu_wr_idx,
   input  logic [1:0]       cpu_wr_state,
   input  logic             snp_wr_en,
   input  logic [IDX_W-1:0] snp_wr_idx,
   input  logic [1:0]       snp_wr_state
);

   logic [1:0] line_state [NUM_LINES];

   assign cpu_rd_state = line_state[cpu_rd_idx];
   assign snp_rd_state = line_state[snp_rd_idx];

   // The cpu write comes last so it wins on an index collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_LINES; i++) line_state[i] <= LINE_I;
      end else begin
         if (snp_wr_en) line_state[snp_wr_idx] <= snp_wr_state;
         if (cpu_wr_en) line_state[cpu_wr_idx] <= cpu_wr_state;
      end
   end

endmodule

// File: rtl/coh_line_ctrl.sv
// Multi-line MSI/MESI controller: serialises CPU requests onto a snooping bus via req/gnt
// and applies snooped traffic to the line states every cycle.
module coh_line_ctrl
   import coh_pkg::*;
#(
   parameter int NUM_LINES = 16,
   parameter int IDX_W     = 4,
   parameter int MESI_EN   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_valid,
   output logic             cpu_ready,
   input  logic             cpu_write,
   input  logic [IDX_W-1:0] cpu_idx,
   output logic             cpu_done,
   output logic             cpu_hit,
   output logic             bus_req,
   input  logic             bus_gnt,
   output logic [1:0]       bus_op,
   output logic [IDX_W-1:0] bus_idx,
   input  logic             bus_shared_in,
   input  logic             snp_valid,
   input  logic [1:0]       snp_op,
   input  logic [IDX_W-1:0] snp_idx,
   output logic             snp_flush,
   output logic             snp_shared,
   output logic             err
);

   fsm_state_t       state;
   logic [1:0]       cpu_line;
   logic [1:0]       snp_line;
   logic [1:0]       snp_line_next;
   logic             accept;
   logic             lookup_hit;
   logic [1:0]       miss_op;
   logic             gnt_now;
   logic             snp_hits_req;
   logic             cpu_wr_en;
   logic [IDX_W-1:0] cpu_wr_idx;
   logic [1:0]       cpu_wr_state;

   coh_state_array #(.NUM_LINES(NUM_LINES), .IDX_W(IDX_W)) u_array (
      .clk          (clk),
      .rst          (rst),
      .cpu_rd_idx   (cpu_idx),
      .cpu_rd_state (cpu_line),
      .snp_rd_idx   (snp_idx),
      .snp_rd_state (snp_line),
      .cpu_wr_en    (cpu_wr_en),
      .cpu_wr_idx   (cpu_wr_idx),
      .cpu_wr_state (cpu_wr_state),
      .snp_wr_en    (snp_valid),
      .snp_wr_idx   (snp_idx),
      .snp_wr_state (snp_line_next)
   );

   // A same-line snoop stalls acceptance so the lookup never races the snoop update.
   assign cpu_ready     = !rst && (state == FSM_IDLE) && !(snp_valid && (snp_idx == cpu_idx));
   assign accept        = cpu_valid && cpu_ready;
   assign snp_line_next = snoop_next(snp_line, snp_op);
   assign gnt_now       = (state == FSM_ARB) && bus_gnt;
   assign snp_hits_req  = snp_valid && (snp_idx == bus_idx);

   always_comb begin
      lookup_hit = 1'b0;
      miss_op    = OP_READ_MISS;
      if (cpu_write) begin
         lookup_hit = (cpu_line == LINE_M) || (cpu_line == LINE_E);
         miss_op    = (cpu_line == LINE_S) ? OP_INVALIDATE : OP_WRITE_MISS;
      end else begin
         lookup_hit = (cpu_line != LINE_I);
      end
   end

   // Silent E->M upgrade on a write hit, or the fill/upgrade result on our own grant.
   always_comb begin
      cpu_wr_en    = 1'b0;
      cpu_wr_idx   = cpu_idx;
      cpu_wr_state = LINE_M;
      if (accept && cpu_write && (cpu_line == LINE_E)) begin
         cpu_wr_en = 1'b1;
      end else if (gnt_now) begin
         cpu_wr_en  = 1'b1;
         cpu_wr_idx = bus_idx;
         if (bus_op == OP_READ_MISS)
            cpu_wr_state = ((MESI_EN != 0) && !bus_shared_in) ? LINE_E : LINE_S;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FSM_IDLE;
         cpu_done <= 1'b0;
         cpu_hit  <= 1'b0;
         bus_req  <= 1'b0;
         bus_op   <= 2'b00;
         bus_idx  <= '0;
      end else begin
         cpu_done <= 1'b0;
         cpu_hit  <= 1'b0;
         case (state)
            FSM_IDLE: begin
               if (accept) begin
                  if (lookup_hit) begin
                     state    <= FSM_DONE;
                     cpu_done <= 1'b1;
                     cpu_hit  <= 1'b1;
                  end else begin
                     state   <= FSM_ARB;
                     bus_req <= 1'b1;
                     bus_op  <= miss_op;
                     bus_idx <= cpu_idx;
                  end
               end
            end
            FSM_ARB: begin
               if (bus_gnt) begin
                  state    <= FSM_DONE;
                  bus_req  <= 1'b0;
                  cpu_done <= 1'b1;
               end else if (snp_hits_req && (bus_op == OP_INVALIDATE) &&
                            (snp_line_next == LINE_I)) begin
                  // Our shared copy was lost while waiting, so an upgrade now needs the data.
                  bus_op <= OP_WRITE_MISS;
               end
            end
            FSM_DONE: state <= FSM_IDLE;
            default:  state <= FSM_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         snp_flush  <= 1'b0;
         snp_shared <= 1'b0;
         err        <= 1'b0;
      end else begin
         snp_flush  <= snp_valid && (snp_line == LINE_M) &&
                       ((snp_op == OP_READ_MISS) || (snp_op == OP_WRITE_MISS));
         snp_shared <= snp_valid && (snp_line != LINE_I);
         if ((snp_valid && (snp_op == OP_INVALIDATE) && (snp_line == LINE_M)) ||
             (gnt_now && snp_hits_req))
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_coh_line_ctrl.sv
// Self-checking bench for coh_line_ctrl: one MSI and one MESI instance, a snoop-rule table,
// hand-written multi-cycle sequences, and a randomized run against a transaction-level model.
module tb_coh_line_ctrl;

   localparam logic [1:0] ST_I = 2'b00;
   localparam logic [1:0] ST_M = 2'b01;
   localparam logic [1:0] ST_S = 2'b10;
   localparam logic [1:0] ST_E = 2'b11;
   localparam logic [1:0] OP_INV = 2'b00;
   localparam logic [1:0] OP_WM  = 2'b01;
   localparam logic [1:0] OP_RM  = 2'b10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst           [2];
   logic       cpu_valid     [2];
   logic       cpu_ready     [2];
   logic       cpu_write     [2];
   logic [3:0] cpu_idx       [2];
   logic       cpu_done      [2];
   logic       cpu_hit       [2];
   logic       bus_req       [2];
   logic       bus_gnt       [2];
   logic [1:0] bus_op        [2];
   logic [3:0] bus_idx       [2];
   logic       bus_shared_in [2];
   logic       snp_valid     [2];
   logic [1:0] snp_op        [2];
   logic [3:0] snp_idx       [2];
   logic       snp_flush     [2];
   logic       snp_shared    [2];
   logic       err           [2];
   logic [1:0] line_view     [2][16];

   int checks = 0;
   int errors = 0;

   coh_line_ctrl #(.NUM_LINES(16), .IDX_W(4), .MESI_EN(0)) u_msi (
      .clk(clk), .rst(rst[0]), .cpu_valid(cpu_valid[0]), .cpu_ready(cpu_ready[0]),
      .cpu_write(cpu_write[0]), .cpu_idx(cpu_idx[0]), .cpu_done(cpu_done[0]), .cpu_hit(cpu_hit[0]),
      .bus_req(bus_req[0]), .bus_gnt(bus_gnt[0]), .bus_op(bus_op[0]), .bus_idx(bus_idx[0]),
      .bus_shared_in(bus_shared_in[0]), .snp_valid(snp_valid[0]), .snp_op(snp_op[0]),
      .snp_idx(snp_idx[0]), .snp_flush(snp_flush[0]), .snp_shared(snp_shared[0]), .err(err[0])
   );

   coh_line_ctrl #(.NUM_LINES(16), .IDX_W(4), .MESI_EN(1)) u_mesi (
      .clk(clk), .rst(rst[1]), .cpu_valid(cpu_valid[1]), .cpu_ready(cpu_ready[1]),
      .cpu_write(cpu_write[1]), .cpu_idx(cpu_idx[1]), .cpu_done(cpu_done[1]), .cpu_hit(cpu_hit[1]),
      .bus_req(bus_req[1]), .bus_gnt(bus_gnt[1]), .bus_op(bus_op[1]), .bus_idx(bus_idx[1]),
      .bus_shared_in(bus_shared_in[1]), .snp_valid(snp_valid[1]), .snp_op(snp_op[1]),
      .snp_idx(snp_idx[1]), .snp_flush(snp_flush[1]), .snp_shared(snp_shared[1]), .err(err[1])
   );

   for (genvar g = 0; g < 16; g++) begin : g_view
      assign line_view[0][g] = u_msi.u_array.line_state[g];
      assign line_view[1][g] = u_mesi.u_array.line_state[g];
   end

   typedef struct {
      logic [1:0] init_st;
      logic [1:0] op;
      logic       exp_flush;
      logic       exp_shared;
      logic [1:0] exp_st;
      logic       exp_err;
   } snp_vec_t;

   snp_vec_t vecs [12];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input int d, input logic cv, input logic cw, input logic [3:0] ci,
                                input logic sv, input logic [1:0] so, input logic [3:0] si,
                                input logic gnt, input logic sh);
      cpu_valid[d] = cv;  cpu_write[d] = cw;  cpu_idx[d] = ci;
      snp_valid[d] = sv;  snp_op[d]    = so;  snp_idx[d] = si;
      bus_gnt[d]   = gnt; bus_shared_in[d] = sh;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut(input int d, input bit chk);
      applyStimulus(d, 0, 0, 0, 0, 0, 0, 0, 0);
      rst[d] = 1'b1;
      cycle();
      cycle();
      if (chk) begin
         checkOutput("rst_ready",  cpu_ready[d],  0);
         checkOutput("rst_done",   cpu_done[d],   0);
         checkOutput("rst_hit",    cpu_hit[d],    0);
         checkOutput("rst_req",    bus_req[d],    0);
         checkOutput("rst_op",     bus_op[d],     0);
         checkOutput("rst_idx",    bus_idx[d],    0);
         checkOutput("rst_flush",  snp_flush[d],  0);
         checkOutput("rst_shared", snp_shared[d], 0);
         checkOutput("rst_err",    err[d],        0);
      end
      rst[d] = 1'b0;
   endtask

   // Issue one CPU request, grant the bus gnt_wait cycles after bus_req, return cpu_hit.
   task automatic run_req(input int d, input logic wr, input logic [3:0] idx, input logic sh,
                          input int gnt_wait, output logic hit);
      bit acc = 0;
      bit got = 0;
      int w = 0;
      hit = 1'b0;
      applyStimulus(d, 1, wr, idx, 0, 0, 0, 0, 0);
      for (int k = 0; k < 10 && !acc; k++) begin
         #1;
         acc = cpu_ready[d];
         cycle();
      end
      cpu_valid[d] = 1'b0;
      checkOutput("req_accept_timeout", acc, 1);
      for (int k = 0; k < 50 && !got; k++) begin
         if (cpu_done[d]) begin
            got = 1;
            hit = cpu_hit[d];
         end else begin
            if (bus_req[d]) begin
               if (w == gnt_wait) begin
                  bus_gnt[d] = 1'b1;
                  bus_shared_in[d] = sh;
               end
               w++;
            end
            cycle();
            bus_gnt[d] = 1'b0;
         end
      end
      checkOutput("req_done_timeout", got, 1);
      cycle();
   endtask

   task automatic set_line(input int d, input logic [3:0] idx, input logic [1:0] st);
      logic h;
      case (st)
         ST_S: run_req(d, 0, idx, 1, 1, h);
         ST_E: run_req(d, 0, idx, 0, 1, h);
         ST_M: run_req(d, 1, idx, 1, 1, h);
         default: ;
      endcase
      checkOutput("setup_line", line_view[d][idx], st);
   endtask

   function automatic logic [1:0] snoop_rule(input logic [1:0] st, input logic [1:0] op);
      if (op == OP_RM) return (st == ST_M || st == ST_E) ? ST_S : st;
      return ST_I;
   endfunction

   // Randomized run: the model tracks line states plus the one outstanding request.
   task automatic random_run(input int d, input int n);
      logic [1:0] m_line [16];
      int         phase;
      logic [1:0] m_op, cur, snp_new, wr_val, so;
      logic [3:0] m_idx, ci, si, wr_idx;
      logic       m_err, e_done, e_hit, e_flush, e_shared, e_ready;
      logic       cv, cw, sv, gnt, sh, r, wr_en;
      int         t;
      reset_dut(d, 0);
      foreach (m_line[i]) m_line[i] = ST_I;
      phase = 0; m_op = 0; m_idx = 0; m_err = 0;
      e_done = 0; e_hit = 0; e_flush = 0; e_shared = 0;
      for (int c = 0; c < n; c++) begin
         checkOutput("rnd_done",   cpu_done[d],   e_done);
         checkOutput("rnd_hit",    cpu_hit[d],    e_hit);
         checkOutput("rnd_req",    bus_req[d],    phase == 1);
         if (phase == 1) begin
            checkOutput("rnd_op",  bus_op[d],  m_op);
            checkOutput("rnd_idx", bus_idx[d], m_idx);
         end
         checkOutput("rnd_flush",  snp_flush[d],  e_flush);
         checkOutput("rnd_shared", snp_shared[d], e_shared);
         checkOutput("rnd_err",    err[d],        m_err);
         for (int i = 0; i < 16; i++) checkOutput("rnd_line", line_view[d][i], m_line[i]);

         r  = ($urandom % 100) == 0;
         cv = $urandom % 2;  cw = $urandom % 2;  ci = 4'($urandom % 4);
         sv = ($urandom % 10) < 4;
         t  = $urandom % 10;
         so = (t < 4) ? OP_RM : ((t < 8) ? OP_WM : OP_INV);
         si = 4'($urandom % 4);
         gnt = (phase == 1) && (($urandom % 3) == 0);
         sh = $urandom % 2;
         applyStimulus(d, cv, cw, ci, sv, so, si, gnt, sh);
         rst[d] = r;
         #1;
         e_ready = !r && phase == 0 && !(sv && si == ci);
         checkOutput("rnd_ready", cpu_ready[d], e_ready);

         if (r) begin
            foreach (m_line[i]) m_line[i] = ST_I;
            phase = 0; m_op = 0; m_idx = 0; m_err = 0;
            e_done = 0; e_hit = 0; e_flush = 0; e_shared = 0;
         end else begin
            wr_en = 0; wr_idx = 0; wr_val = ST_M; snp_new = ST_I;
            e_done = 0; e_hit = 0; e_flush = 0; e_shared = 0;
            if (sv) begin
               cur      = m_line[si];
               snp_new  = snoop_rule(cur, so);
               e_shared = cur != ST_I;
               e_flush  = cur == ST_M && so != OP_INV;
               if (so == OP_INV && cur == ST_M) m_err = 1;
            end
            if (phase == 0) begin
               if (e_ready && cv) begin
                  cur = m_line[ci];
                  if ((!cw && cur != ST_I) || (cw && (cur == ST_M || cur == ST_E))) begin
                     phase = 2; e_done = 1; e_hit = 1;
                     if (cw && cur == ST_E) begin wr_en = 1; wr_idx = ci; wr_val = ST_M; end
                  end else begin
                     phase = 1; m_idx = ci;
                     m_op = !cw ? OP_RM : (cur == ST_S ? OP_INV : OP_WM);
                  end
               end
            end else if (phase == 1) begin
               if (gnt) begin
                  wr_en = 1; wr_idx = m_idx;
                  wr_val = (m_op != OP_RM) ? ST_M : ((d == 1 && !sh) ? ST_E : ST_S);
                  if (sv && si == m_idx) m_err = 1;
                  phase = 2; e_done = 1;
               end else if (sv && si == m_idx && snp_new == ST_I && m_op == OP_INV) begin
                  m_op = OP_WM;
               end
            end else begin
               phase = 0;
            end
            if (sv) m_line[si] = snp_new;
            if (wr_en) m_line[wr_idx] = wr_val;
         end
         cycle();
      end
      rst[d] = 1'b0;
      applyStimulus(d, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic h;
      vecs[0]  = '{ST_I, OP_RM,  0, 0, ST_I, 0};
      vecs[1]  = '{ST_I, OP_WM,  0, 0, ST_I, 0};
      vecs[2]  = '{ST_I, OP_INV, 0, 0, ST_I, 0};
      vecs[3]  = '{ST_S, OP_RM,  0, 1, ST_S, 0};
      vecs[4]  = '{ST_S, OP_WM,  0, 1, ST_I, 0};
      vecs[5]  = '{ST_S, OP_INV, 0, 1, ST_I, 0};
      vecs[6]  = '{ST_E, OP_RM,  0, 1, ST_S, 0};
      vecs[7]  = '{ST_E, OP_WM,  0, 1, ST_I, 0};
      vecs[8]  = '{ST_E, OP_INV, 0, 1, ST_I, 0};
      vecs[9]  = '{ST_M, OP_RM,  1, 1, ST_S, 0};
      vecs[10] = '{ST_M, OP_WM,  1, 1, ST_I, 0};
      vecs[11] = '{ST_M, OP_INV, 0, 1, ST_I, 1};

      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1;
         applyStimulus(d, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      reset_dut(0, 1);
      reset_dut(1, 1);

      $display("[TB] read miss on MSI instance");
      applyStimulus(0, 1, 0, 3, 0, 0, 0, 0, 0);
      #1;
      checkOutput("t1_ready", cpu_ready[0], 1);
      cycle();
      cpu_valid[0] = 1'b0;
      checkOutput("t1_req", bus_req[0], 1);
      checkOutput("t1_op", bus_op[0], OP_RM);
      checkOutput("t1_idx", bus_idx[0], 3);
      checkOutput("t1_nodone", cpu_done[0], 0);
      repeat (3) cycle();
      checkOutput("t1_req_held", bus_req[0], 1);
      bus_gnt[0] = 1'b1;
      bus_shared_in[0] = 1'b0;
      cycle();
      bus_gnt[0] = 1'b0;
      checkOutput("t1_done", cpu_done[0], 1);
      checkOutput("t1_hit", cpu_hit[0], 0);
      checkOutput("t1_req_drop", bus_req[0], 0);
      checkOutput("t1_line", line_view[0][3], ST_S);
      cycle();
      checkOutput("t1_done_pulse", cpu_done[0], 0);

      $display("[TB] MESI exclusive fill then silent upgrade");
      run_req(1, 0, 5, 0, 2, h);
      checkOutput("t2_miss", h, 0);
      checkOutput("t2_line_e", line_view[1][5], ST_E);
      applyStimulus(1, 1, 1, 5, 0, 0, 0, 0, 0);
      cycle();
      cpu_valid[1] = 1'b0;
      checkOutput("t2_done", cpu_done[1], 1);
      checkOutput("t2_hit", cpu_hit[1], 1);
      checkOutput("t2_noreq", bus_req[1], 0);
      checkOutput("t2_line_m", line_view[1][5], ST_M);
      cycle();

      $display("[TB] snoop read on modified line");
      set_line(0, 7, ST_M);
      applyStimulus(0, 0, 0, 0, 1, OP_RM, 7, 0, 0);
      cycle();
      snp_valid[0] = 1'b0;
      checkOutput("t3_flush", snp_flush[0], 1);
      checkOutput("t3_shared", snp_shared[0], 1);
      checkOutput("t3_line", line_view[0][7], ST_S);
      cycle();
      checkOutput("t3_flush_pulse", snp_flush[0], 0);

      $display("[TB] upgrade converted to write miss by remote write");
      set_line(0, 2, ST_S);
      applyStimulus(0, 1, 1, 2, 0, 0, 0, 0, 0);
      cycle();
      cpu_valid[0] = 1'b0;
      checkOutput("t4_op_inv", bus_op[0], OP_INV);
      checkOutput("t4_req", bus_req[0], 1);
      applyStimulus(0, 0, 0, 0, 1, OP_WM, 2, 0, 0);
      cycle();
      snp_valid[0] = 1'b0;
      checkOutput("t4_op_wm", bus_op[0], OP_WM);
      checkOutput("t4_req_held", bus_req[0], 1);
      checkOutput("t4_line_i", line_view[0][2], ST_I);
      bus_gnt[0] = 1'b1;
      cycle();
      bus_gnt[0] = 1'b0;
      checkOutput("t4_done", cpu_done[0], 1);
      checkOutput("t4_line_m", line_view[0][2], ST_M);
      checkOutput("t4_err", err[0], 0);
      cycle();

      $display("[TB] same-line snoop stalls acceptance");
      applyStimulus(0, 1, 0, 9, 1, OP_RM, 9, 0, 0);
      #1;
      checkOutput("t5_stall", cpu_ready[0], 0);
      cycle();
      checkOutput("t5_not_taken", bus_req[0], 0);
      snp_valid[0] = 1'b0;
      #1;
      checkOutput("t5_ready", cpu_ready[0], 1);
      cycle();
      cpu_valid[0] = 1'b0;
      checkOutput("t5_req", bus_req[0], 1);
      checkOutput("t5_idx", bus_idx[0], 9);
      bus_gnt[0] = 1'b1;
      cycle();
      bus_gnt[0] = 1'b0;
      cycle();

      $display("[TB] MSI never fills exclusive");
      run_req(0, 0, 11, 0, 0, h);
      checkOutput("msi_no_e", line_view[0][11], ST_S);

      $display("[TB] reset during arbitration");
      set_line(0, 4, ST_M);
      applyStimulus(0, 1, 0, 6, 0, 0, 0, 0, 0);
      cycle();
      cpu_valid[0] = 1'b0;
      checkOutput("t6_req", bus_req[0], 1);
      rst[0] = 1'b1;
      cycle();
      rst[0] = 1'b0;
      checkOutput("t6_req_drop", bus_req[0], 0);
      checkOutput("t6_err", err[0], 0);
      for (int i = 0; i < 16; i++) checkOutput("t6_line_i", line_view[0][i], ST_I);
      for (int k = 0; k < 3; k++) begin
         checkOutput("t6_no_done", cpu_done[0], 0);
         cycle();
      end
      set_line(0, 8, ST_M);
      applyStimulus(0, 0, 0, 0, 1, OP_INV, 8, 0, 0);
      cycle();
      snp_valid[0] = 1'b0;
      checkOutput("t6_err_set", err[0], 1);
      checkOutput("t6_line8", line_view[0][8], ST_I);
      repeat (4) cycle();
      checkOutput("t6_err_sticky", err[0], 1);

      $display("[TB] grant colliding with snoops");
      reset_dut(1, 0);
      set_line(1, 1, ST_M);
      applyStimulus(1, 1, 0, 10, 0, 0, 0, 0, 0);
      cycle();
      applyStimulus(1, 0, 0, 0, 1, OP_WM, 1, 1, 0);
      cycle();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("gx_done", cpu_done[1], 1);
      checkOutput("gx_line10", line_view[1][10], ST_E);
      checkOutput("gx_line1", line_view[1][1], ST_I);
      checkOutput("gx_flush", snp_flush[1], 1);
      checkOutput("gx_err_clear", err[1], 0);
      cycle();
      applyStimulus(1, 1, 0, 13, 0, 0, 0, 0, 0);
      cycle();
      applyStimulus(1, 0, 0, 0, 1, OP_WM, 13, 1, 1);
      cycle();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("gx_own_wins", line_view[1][13], ST_S);
      checkOutput("gx_err", err[1], 1);
      cycle();

      $display("[TB] snoop rule table");
      for (int v = 0; v < 12; v++) begin
         reset_dut(1, 0);
         set_line(1, 12, vecs[v].init_st);
         applyStimulus(1, 0, 0, 0, 1, vecs[v].op, 12, 0, 0);
         cycle();
         snp_valid[1] = 1'b0;
         checkOutput($sformatf("vec%0d_flush", v),  snp_flush[1],      vecs[v].exp_flush);
         checkOutput($sformatf("vec%0d_shared", v), snp_shared[1],     vecs[v].exp_shared);
         checkOutput($sformatf("vec%0d_line", v),   line_view[1][12],  vecs[v].exp_st);
         checkOutput($sformatf("vec%0d_err", v),    err[1],            vecs[v].exp_err);
      end

      $display("[TB] randomized run");
      random_run(0, 600);
      random_run(1, 600);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
